// File: rtl/fusion_integrator_cal_if.sv
// Handshake/data bundle between the inertial front end and fusion_integrator_cal.
// master drives raw readings and requests; slave (the integrator) returns fused angles and status.
interface fusion_integrator_cal_if #(
    parameter int OUT_W = 13
);
    logic                    vld;
    logic                    cal_start;
    logic signed [15:0]      roll_rt;
    logic signed [15:0]      yaw_rt;
    logic signed [15:0]      AY;
    logic signed [15:0]      AZ;
    logic signed [OUT_W-1:0] incline;
    logic signed [OUT_W-1:0] roll;
    logic                    out_vld;
    logic                    cal_busy;
    logic                    cal_done;

    modport master (
        output vld, cal_start, roll_rt, yaw_rt, AY, AZ,
        input  incline, roll, out_vld, cal_busy, cal_done
    );

    modport slave (
        input  vld, cal_start, roll_rt, yaw_rt, AY, AZ,
        output incline, roll, out_vld, cal_busy, cal_done
    );
endinterface

// File: rtl/fusion_integrator_cal.sv
// Two-axis complementary-filter integrator with runtime gyro-offset calibration; LEAN_ZERO_EN gates incline on large roll.
// Latency: vld seen at edge N -> S1 at N+1 -> integrators and out_vld at N+2; one sample per cycle sustained.
// Backpressure: none; vld is a strobe, samples arriving during calibration feed the offset average only.
module fusion_integrator_cal #(
    parameter int          INT_W        = 24,
    parameter int          OUT_W        = 13,
    parameter int          LEAK         = 1024,
    parameter int          ACC_GAIN     = 327,
    parameter int          ACC_SHIFT    = 13,
    parameter int          CAL_LOG      = 4,
    parameter logic [15:0] DEF_YAW_OFF  = 16'h0054,
    parameter logic [15:0] DEF_ROLL_OFF = 16'h0000,
    parameter int          ROLL_THRES   = 152
) (
    input logic                clk,
    input logic                rst_n,
    fusion_integrator_cal_if.slave bus
);

    localparam int SUM_W = INT_W + 2;
    localparam int CS_W  = 16 + CAL_LOG;
    localparam logic signed [SUM_W-1:0] LEAK_P  = SUM_W'(LEAK);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((longint'(1) <<< (INT_W-1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [25:0]      GAIN_P  = 26'(ACC_GAIN);
    localparam logic signed [25:0]      GAIN_N  = -GAIN_P;
    localparam logic [OUT_W:0]          THR     = (OUT_W+1)'(ROLL_THRES);

    typedef enum logic {RUN, CAL} state_t;
    state_t state;

    logic                    c_vld, s1_vld;
    logic signed [15:0]      c_roll, c_yaw, c_ay, c_az;
    logic signed [15:0]      s1_roll_raw, s1_yaw_raw;
    logic signed [16:0]      s1_roll_comp, s1_yaw_comp;
    logic signed [25:0]      s1_inc_prod, s1_roll_prod;
    logic signed [15:0]      yaw_off, roll_off;
    logic signed [INT_W-1:0] inc_int, roll_int;
    logic signed [CS_W-1:0]  yaw_sum, roll_sum;
    logic [CAL_LOG-1:0]      cal_cnt;
    logic                    out_vld, cal_done;

    // S1 combinational: accel products and offset-compensated rates
    logic signed [25:0] inc_prod, roll_prod;
    logic signed [16:0] yaw_comp, roll_comp;
    assign inc_prod  = $signed({{10{c_ay[15]}}, c_ay}) * GAIN_N;
    assign roll_prod = $signed({{10{c_az[15]}}, c_az}) * GAIN_P;
    assign yaw_comp  = $signed({c_yaw[15], c_yaw}) - $signed({yaw_off[15], yaw_off});
    assign roll_comp = $signed({c_roll[15], c_roll}) - $signed({roll_off[15], roll_off});

    // S2 combinational: leak direction from accel angle vs current angle, then saturate
    logic signed [OUT_W-1:0] inc_acc, roll_acc, inc_ang, roll_ang;
    logic signed [SUM_W-1:0] inc_nxt, roll_nxt;
    assign inc_acc  = s1_inc_prod[ACC_SHIFT +: OUT_W];
    assign roll_acc = s1_roll_prod[ACC_SHIFT +: OUT_W];
    assign inc_ang  = inc_int[INT_W-1 -: OUT_W];
    assign roll_ang = roll_int[INT_W-1 -: OUT_W];
    assign inc_nxt  = $signed({{2{inc_int[INT_W-1]}}, inc_int})
                    + $signed({{(SUM_W-17){s1_yaw_comp[16]}}, s1_yaw_comp})
                    + ((inc_acc > inc_ang) ? LEAK_P : -LEAK_P);
    assign roll_nxt = $signed({{2{roll_int[INT_W-1]}}, roll_int})
                    + $signed({{(SUM_W-17){s1_roll_comp[16]}}, s1_roll_comp})
                    + ((roll_acc > roll_ang) ? LEAK_P : -LEAK_P);

    function automatic logic signed [INT_W-1:0] sat(input logic signed [SUM_W-1:0] s);
        if (s > SAT_MAX)      return SAT_MAX[INT_W-1:0];
        else if (s < SAT_MIN) return SAT_MIN[INT_W-1:0];
        else                  return s[INT_W-1:0];
    endfunction

    logic signed [CS_W-1:0] yaw_sum_nxt, roll_sum_nxt;
    assign yaw_sum_nxt  = yaw_sum  + $signed({{CAL_LOG{s1_yaw_raw[15]}}, s1_yaw_raw});
    assign roll_sum_nxt = roll_sum + $signed({{CAL_LOG{s1_roll_raw[15]}}, s1_roll_raw});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_vld        <= 1'b0;
            c_roll       <= '0;
            c_yaw        <= '0;
            c_ay         <= '0;
            c_az         <= '0;
            s1_vld       <= 1'b0;
            s1_roll_raw  <= '0;
            s1_yaw_raw   <= '0;
            s1_roll_comp <= '0;
            s1_yaw_comp  <= '0;
            s1_inc_prod  <= '0;
            s1_roll_prod <= '0;
        end else begin
            c_vld  <= bus.vld;
            s1_vld <= c_vld;
            if (bus.vld) begin
                c_roll <= bus.roll_rt;
                c_yaw  <= bus.yaw_rt;
                c_ay   <= bus.AY;
                c_az   <= bus.AZ;
            end
            if (c_vld) begin
                s1_roll_raw  <= c_roll;
                s1_yaw_raw   <= c_yaw;
                s1_roll_comp <= roll_comp;
                s1_yaw_comp  <= yaw_comp;
                s1_inc_prod  <= inc_prod;
                s1_roll_prod <= roll_prod;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            inc_int  <= '0;
            roll_int <= '0;
            yaw_off  <= DEF_YAW_OFF;
            roll_off <= DEF_ROLL_OFF;
            yaw_sum  <= '0;
            roll_sum <= '0;
            cal_cnt  <= '0;
            out_vld  <= 1'b0;
            cal_done <= 1'b0;
        end else begin
            out_vld  <= 1'b0;
            cal_done <= 1'b0;
            case (state)
                RUN: begin
                    if (s1_vld) begin
                        inc_int  <= sat(inc_nxt);
                        roll_int <= sat(roll_nxt);
                        out_vld  <= 1'b1;
                    end
                    if (bus.cal_start) begin
                        state    <= CAL;
                        yaw_sum  <= '0;
                        roll_sum <= '0;
                        cal_cnt  <= '0;
                    end
                end
                CAL: begin
                    // integrators frozen; every sample reaching S2 feeds the average
                    if (s1_vld) begin
                        yaw_sum  <= yaw_sum_nxt;
                        roll_sum <= roll_sum_nxt;
                        cal_cnt  <= cal_cnt + 1'b1;
                        if (&cal_cnt) begin
                            yaw_off  <= yaw_sum_nxt[CAL_LOG +: 16];
                            roll_off <= roll_sum_nxt[CAL_LOG +: 16];
                            inc_int  <= '0;
                            roll_int <= '0;
                            cal_done <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    logic signed [OUT_W-1:0] inc_out, roll_out;
    assign inc_out  = inc_int[INT_W-1 -: OUT_W];
    assign roll_out = roll_int[INT_W-1 -: OUT_W];

`ifdef LEAN_ZERO_EN
    // one extra bit so that |most-negative| is representable
    logic [OUT_W:0] roll_abs;
    assign roll_abs    = roll_out[OUT_W-1] ? -$signed({roll_out[OUT_W-1], roll_out})
                                           : {1'b0, roll_out};
    assign bus.incline = (roll_abs > THR) ? '0 : inc_out;
`else
    assign bus.incline = inc_out;
`endif

    assign bus.roll     = roll_out;
    assign bus.out_vld  = out_vld;
    assign bus.cal_done = cal_done;
    assign bus.cal_busy = (state == CAL);

    logic unused_bits;
    assign unused_bits = ^{s1_inc_prod, s1_roll_prod, yaw_sum_nxt, roll_sum_nxt, THR};

endmodule

// File: tb/tb_fusion_integrator_cal.sv
// Directed bench for fusion_integrator_cal: reset, latency, leak tie, calibration, saturation, roll gating.
module tb_fusion_integrator_cal;

    logic clk;
    logic rst_n;

    fusion_integrator_cal_if #(.OUT_W(13)) bus ();

    fusion_integrator_cal dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk       = 0;
    int n_fail      = 0;
    int cal_vld_cnt = 0;
    int neg_cnt     = 0;
    bit mon_cal     = 1'b0;
    bit mon_sat     = 1'b0;

    logic [15:0] ln_roll [3] = '{16'h76A8, 16'h75E0, 16'h8A20};
    logic [15:0] ln_az   [3] = '{16'h7FFF, 16'h7FFF, 16'h8001};
    int          ln_roll_exp [3] = '{153, 152, -153};
`ifdef LEAN_ZERO_EN
    int          ln_inc_exp  [3] = '{0, 53, 0};
`else
    int          ln_inc_exp  [3] = '{53, 53, 53};
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_cal && bus.cal_busy && bus.out_vld) cal_vld_cnt++;
        if (mon_sat && bus.incline[12]) neg_cnt++;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // one sample; returns 1ns after the edge that updates the integrators
    task automatic send(input logic [15:0] r, input logic [15:0] y,
                        input logic [15:0] ay, input logic [15:0] az);
        bus.roll_rt = r;
        bus.yaw_rt  = y;
        bus.AY      = ay;
        bus.AZ      = az;
        bus.vld     = 1'b1;
        @(posedge clk); #1;
        bus.vld       = 1'b0;
        bus.cal_start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.vld       = 1'b0;
        bus.cal_start = 1'b0;
        bus.roll_rt   = '0;
        bus.yaw_rt    = '0;
        bus.AY        = '0;
        bus.AZ        = '0;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_incline",  bus.incline,  0);
        chk("rst_roll",     bus.roll,     0);
        chk("rst_out_vld",  bus.out_vld,  0);
        chk("rst_cal_busy", bus.cal_busy, 0);
        chk("rst_cal_done", bus.cal_done, 0);
        chk("rst_yaw_off",  dut.yaw_off,  84);
        chk("rst_roll_off", dut.roll_off, 0);
        chk("rst_inc_int",  dut.inc_int,  0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // latency: comp yaw 100, acc_ang 1144 > 0 -> +LEAK
        bus.yaw_rt = 16'h00B8;
        bus.AY     = 16'h9000;
        bus.vld    = 1'b1;
        @(posedge clk); #1;
        bus.vld = 1'b0;
        chk("lat_n0_out_vld", bus.out_vld, 0);
        @(posedge clk); #1;
        chk("lat_n1_out_vld", bus.out_vld, 0);
        chk("lat_n1_inc_int", dut.inc_int, 0);
        @(posedge clk); #1;
        chk("lat_n2_out_vld", bus.out_vld, 1);
        chk("lat_inc_int",    dut.inc_int, 1124);
        chk("tie_roll_int0",  dut.roll_int, -1024);
        chk("lat_roll_out",   bus.roll, -1);
        @(posedge clk); #1;
        chk("lat_n3_out_vld", bus.out_vld, 0);

        // leak ties: incline acc 0 == ang 0, roll acc -1 == ang -1
        send(16'h0000, 16'h0054, 16'h0000, 16'hFFFF);
        chk("tie_inc_int1",  dut.inc_int,  100);
        chk("tie_roll_int1", dut.roll_int, -2048);
        send(16'h0000, 16'h0054, 16'h0000, 16'hFFFF);
        chk("tie_inc_int2",  dut.inc_int,  -924);
        chk("tie_roll_int2", dut.roll_int, -3072);

        // calibration with a stray cal_start halfway through
        bus.cal_start = 1'b1;
        @(posedge clk); #1;
        bus.cal_start = 1'b0;
        chk("cal_busy_start", bus.cal_busy, 1);
        mon_cal = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 7) bus.cal_start = 1'b1;
            send(16'hFFF0, 16'h0060, 16'h0000, 16'h0000);
            if (i == 14) begin
                chk("cal_done_early", bus.cal_done, 0);
                chk("cal_busy_15",    bus.cal_busy, 1);
                chk("cal_frozen_int", dut.inc_int,  -924);
            end
        end
        chk("cal_done",      bus.cal_done, 1);
        chk("cal_busy_end",  bus.cal_busy, 0);
        chk("cal_yaw_off",   dut.yaw_off,  96);
        chk("cal_roll_off",  dut.roll_off, -16);
        chk("cal_inc_int",   dut.inc_int,  0);
        chk("cal_roll_int",  dut.roll_int, 0);
        @(posedge clk); #1;
        chk("cal_done_fall", bus.cal_done, 0);
        mon_cal = 1'b0;
        chk("cal_no_out_vld", cal_vld_cnt, 0);
        send(16'hFFF0, 16'h0060, 16'h0000, 16'h0000);
        chk("post_cal_inc",  dut.inc_int,  -1024);
        chk("post_cal_roll", dut.roll_int, -1024);

        // reset in the middle of a calibration stream
        bus.cal_start = 1'b1;
        @(posedge clk); #1;
        bus.cal_start = 1'b0;
        bus.roll_rt   = 16'h0010;
        bus.yaw_rt    = 16'h0070;
        bus.AY        = 16'h0000;
        bus.AZ        = 16'h0000;
        bus.vld       = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("rstA_busy_before", bus.cal_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstA_incline",  bus.incline,  0);
        chk("rstA_roll",     bus.roll,     0);
        chk("rstA_cal_busy", bus.cal_busy, 0);
        chk("rstA_yaw_off",  dut.yaw_off,  84);
        chk("rstA_roll_off", dut.roll_off, 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        bus.vld = 1'b0;
        @(posedge clk); #1;
        send(16'h0000, 16'h0054, 16'h0000, 16'h0000);
        chk("rstA_def_inc",  dut.inc_int,  -1024);
        chk("rstA_def_roll", dut.roll_int, -1024);

        // saturation: incline to +max, roll to -max, back-to-back samples
        bus.roll_rt = 16'h8000;
        bus.yaw_rt  = 16'h7FFF;
        bus.AY      = 16'h8001;
        bus.AZ      = 16'h7FFF;
        bus.vld     = 1'b1;
        repeat (3) @(posedge clk);
        #1 mon_sat = 1'b1;
        repeat (2000) @(posedge clk);
        #1;
        chk("sat_inc_int",  dut.inc_int,  8388607);
        chk("sat_incline",  bus.incline,  4095);
        chk("sat_roll_int", dut.roll_int, -8388608);
        chk("sat_out_vld",  bus.out_vld,  1);
        #2 mon_sat = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstB_incline", bus.incline, 0);
        chk("rstB_roll",    bus.roll,    0);
        chk("rstB_out_vld", bus.out_vld, 0);
        chk("sat_never_neg", neg_cnt, 0);
        @(posedge clk); #1;
        rst_n   = 1'b1;
        bus.vld = 1'b0;
        @(posedge clk); #1;

        // roll gating around the threshold
        for (int k = 0; k < 3; k++) begin
            pulse_reset();
            repeat (10) send(ln_roll[k], 16'h2764, 16'h8001, ln_az[k]);
            chk($sformatf("lean%0d_roll", k),    bus.roll,    ln_roll_exp[k]);
            chk($sformatf("lean%0d_incline", k), bus.incline, ln_inc_exp[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
